// File: rtl/uart_byte_tx.sv
// 8N1 serial byte transmitter: start bit, 8 data bits LSB first, stop bit, then a one-cycle Tx_Done.
// The bit period is CLK_FREQ/baud, using the baud code captured when the request is accepted.
module uart_byte_tx #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Byte_En,
  input  logic [7:0] Data_Byte,
  input  logic [2:0] Baud_Set,
  output logic       Rs232_Tx,
  output logic       Tx_Done,
  output logic       uart_state
);

  localparam int unsigned CYC_9600   = CLK_FREQ / 9600;
  localparam int unsigned CYC_19200  = CLK_FREQ / 19200;
  localparam int unsigned CYC_38400  = CLK_FREQ / 38400;
  localparam int unsigned CYC_57600  = CLK_FREQ / 57600;
  localparam int unsigned CYC_115200 = CLK_FREQ / 115200;
  localparam int unsigned DIV_W      = (CYC_9600 > 1) ? $clog2(CYC_9600) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_last;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       baud_q, baud_d;
  logic             tx_q, tx_d;
  logic             frame_end, accept;

  // Codes 5..7 fall back to 9600
  always_comb begin
    case (baud_q)
      3'd1:    div_last = DIV_W'(CYC_19200 - 1);
      3'd2:    div_last = DIV_W'(CYC_38400 - 1);
      3'd3:    div_last = DIV_W'(CYC_57600 - 1);
      3'd4:    div_last = DIV_W'(CYC_115200 - 1);
      default: div_last = DIV_W'(CYC_9600 - 1);
    endcase
  end

  function automatic logic line_bit(input logic [3:0] idx, input logic [7:0] data_v);
    if (idx == 4'd0)      return 1'b0;
    else if (idx >= 4'd9) return 1'b1;
    else                  return data_v[3'(idx - 4'd1)];
  endfunction

  assign frame_end = (state_q == S_BUSY) && (bit_cnt_q == 4'd9) && (div_cnt_q == div_last);
  // Accepting in the Tx_Done cycle chains the next start bit right after a full stop bit
  assign accept    = Byte_En && ((state_q == S_IDLE) || frame_end);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    baud_d    = baud_q;
    tx_d      = tx_q;
    if (accept) begin
      state_d   = S_BUSY;
      data_d    = Data_Byte;
      baud_d    = Baud_Set;
      div_cnt_d = '0;
      bit_cnt_d = '0;
      tx_d      = 1'b0;
    end else if (frame_end) begin
      state_d   = S_IDLE;
      div_cnt_d = '0;
      bit_cnt_d = '0;
      tx_d      = 1'b1;
    end else if (state_q == S_BUSY) begin
      if (div_cnt_q == div_last) begin
        div_cnt_d = '0;
        bit_cnt_d = bit_cnt_q + 4'd1;
        tx_d      = line_bit(bit_cnt_q + 4'd1, data_q);
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
    end
  end

  assign Rs232_Tx   = tx_q;
  assign Tx_Done    = frame_end;
  assign uart_state = (state_q == S_BUSY);

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: randomized and directed frames against a frame-level line model.
// A reduced CLK_FREQ keeps every baud's bit period short while preserving the floor arithmetic.
module tb_uart_byte_tx;

  localparam int unsigned CLK_FREQ = 5_000_000;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Byte_En = 1'b0;
  logic [7:0] Data_Byte = 8'h00;
  logic [2:0] Baud_Set = 3'd0;
  logic       Rs232_Tx;
  logic       Tx_Done;
  logic       uart_state;

  int n_cmp = 0;
  int n_err = 0;

  uart_byte_tx #(.CLK_FREQ(CLK_FREQ)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Byte_En(Byte_En), .Data_Byte(Data_Byte),
    .Baud_Set(Baud_Set), .Rs232_Tx(Rs232_Tx), .Tx_Done(Tx_Done), .uart_state(uart_state)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int bit_period(input logic [2:0] b);
    int baud;
    case (b)
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      3'd4:    baud = 115200;
      default: baud = 9600;
    endcase
    return CLK_FREQ / baud;
  endfunction

  task automatic drive_req(input logic [7:0] d, input logic [2:0] b);
    Byte_En   = 1'b1;
    Data_Byte = d;
    Baud_Set  = b;
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_tx"}, 32'(Rs232_Tx), 32'd1);
    chk({tag, "_done"}, 32'(Tx_Done), 32'd0);
    chk({tag, "_state"}, 32'(uart_state), 32'd0);
  endtask

  // Caller has driven the request at a negedge; checks every cycle of the resulting frame.
  // poke_at >= 0 issues an ignored request (8'h3C, code 1) at that frame cycle.
  task automatic check_frame(input logic [7:0] d, input logic [2:0] b, input bit chain,
                             input logic [7:0] nd, input logic [2:0] nb, input int poke_at);
    int         per;
    int         len;
    logic [9:0] frame;
    per   = bit_period(b);
    len   = 10 * per;
    frame = {1'b1, d, 1'b0};
    for (int i = 0; i < len; i++) begin
      @(negedge Clk);
      chk("tx", 32'(Rs232_Tx), 32'(frame[i / per]));
      chk("done", 32'(Tx_Done), 32'(i == len - 1));
      chk("state", 32'(uart_state), 32'd1);
      Byte_En   = 1'b0;
      Data_Byte = 8'($urandom);
      Baud_Set  = 3'($urandom);
      if (i == poke_at) drive_req(8'h3C, 3'd1);
      if (i == len - 1 && chain) drive_req(nd, nb);
    end
    if (!chain) begin
      @(negedge Clk);
      idle_check("post");
    end
  endtask

  initial begin
    logic [7:0] cd, nd;
    logic [2:0] cb, nb;
    bit         chain;
    int         per;

    repeat (3) @(negedge Clk);
    idle_check("rst");
    Rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      idle_check("idle");
    end

    drive_req(8'hA5, 3'd0);
    check_frame(8'hA5, 3'd0, 1'b0, 8'h00, 3'd0, -1);

    drive_req(8'h00, 3'd4);
    check_frame(8'h00, 3'd4, 1'b1, 8'hFF, 3'd4, -1);
    check_frame(8'hFF, 3'd4, 1'b0, 8'h00, 3'd0, -1);

    drive_req(8'hC3, 3'd2);
    check_frame(8'hC3, 3'd2, 1'b0, 8'h00, 3'd0, 3 * bit_period(3'd2) + 7);

    drive_req(8'h55, 3'd7);
    check_frame(8'h55, 3'd7, 1'b0, 8'h00, 3'd0, -1);

    // Reset in the middle of bit 5
    per = bit_period(3'd3);
    drive_req(8'h96, 3'd3);
    for (int i = 0; i < 5 * per + per / 2; i++) begin
      @(negedge Clk);
      Byte_En = 1'b0;
    end
    Rst_n = 1'b0;
    #1;
    idle_check("arst");
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      idle_check("inrst");
    end
    Rst_n = 1'b1;
    @(negedge Clk);
    idle_check("rel");
    drive_req(8'h69, 3'd3);
    check_frame(8'h69, 3'd3, 1'b0, 8'h00, 3'd0, -1);

    cd = 8'($urandom);
    cb = 3'($urandom);
    drive_req(cd, cb);
    for (int r = 0; r < 6; r++) begin
      nd    = 8'($urandom);
      nb    = 3'($urandom);
      chain = (r < 5) && ($urandom_range(0, 1) == 1);
      check_frame(cd, cb, chain, nd, nb,
                  ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10 * bit_period(cb) - 2) : -1);
      cd = nd;
      cb = nb;
      if (!chain && r < 5) drive_req(cd, cb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
